// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit feeding the register-file write port.
// It uses a shift-add multiply and a restoring divide. Each runs one bit per
// cycle over 32 CALC cycles. Divide-by-zero and signed overflow skip CALC.
// Optional macro: MULDIV_FAST_MUL_EN. When it is defined, multiplies use one
// combinational 64-bit multiply and take the same short path as the divide
// special cases.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            we,
    output logic [4:0]      wa
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam logic [2:0]      OP_MUL  = 3'd0;
    localparam logic [2:0]      OP_MULH = 3'd1;
    localparam logic [2:0]      OP_MULHSU = 3'd2;
    localparam logic [2:0]      OP_DIV  = 3'd4;
    localparam logic [2:0]      OP_REM  = 3'd6;
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [5:0]      LAST_IT = 6'(XLEN - 1);

    state_t              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [4:0]          rd_q, rd_d;
    logic [XLEN-1:0]     opb_q, opb_d;     // multiplicand or divisor magnitude
    logic [2*XLEN-1:0]   acc_q, acc_d;     // mul: {hi, lo/multiplier}; div: {rem, quo}
    logic                neg_q, neg_d;
    logic [5:0]          cnt_q, cnt_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic [4:0]          wa_q, wa_d;
    logic                done_q, done_d;

    // Decode the operands at launch: signedness, magnitudes, result sign and the special cases
    logic            is_div, a_sgn, b_sgn, a_neg, b_neg, sign_w, div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag;

    assign is_div   = op[2];
    assign a_sgn    = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    assign b_sgn    = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    assign a_neg    = a_sgn && a[XLEN-1];
    assign b_neg    = b_sgn && b[XLEN-1];
    assign a_mag    = a_neg ? -a : a;
    assign b_mag    = b_neg ? -b : b;
    // The remainder takes the dividend's sign. Quotient and product take the XOR of the signs.
    assign sign_w   = (is_div && op[1]) ? a_neg : (a_neg ^ b_neg);
    assign div_zero = is_div && (b == '0);
    assign div_ovf  = ((op == OP_DIV) || (op == OP_REM)) && (a == MIN_INT) && (b == '1);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] prod_fast;
    assign prod_fast = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
`endif

    // One iteration of the datapath. Multiply adds into the high half and shifts right.
    // Divide does a trial subtract and shifts left.
    logic [XLEN:0]     mul_sum, div_diff;
    logic [2*XLEN-1:0] acc_mul, acc_div;

    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign acc_mul  = {mul_sum, acc_q[XLEN-1:1]};
    assign div_diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opb_q};
    assign acc_div  = div_diff[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                     : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    // Apply the sign to the magnitude result and pick the requested word.
    // The product is negated at full width so the high word is correct.
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   div_sel, div_s, fix_val;

    assign prod_s  = neg_q ? -acc_q : acc_q;
    assign div_sel = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    assign div_s   = neg_q ? -div_sel : div_sel;
    assign fix_val = op_q[2] ? div_s
                   : ((op_q == OP_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN]);

    // Next-state and datapath control for IDLE -> CALC/FIX -> DONE
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        wa_d     = wa_q;
        done_d   = (state_q == DONE);
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d  = op;
                    rd_d  = rd_in;
                    neg_d = sign_w;
                    cnt_d = '0;
                    if (div_zero) begin
                        // The quotient is all ones. The remainder is the raw dividend, so no sign fix applies.
                        acc_d   = {a, {XLEN{1'b1}}};
                        neg_d   = 1'b0;
                        state_d = FIX;
                    end else if (div_ovf) begin
                        acc_d   = {{XLEN{1'b0}}, MIN_INT};
                        neg_d   = 1'b0;
                        state_d = FIX;
                    end else if (is_div) begin
                        acc_d   = {{XLEN{1'b0}}, a_mag};
                        opb_d   = b_mag;
                        state_d = CALC;
                    end else begin
`ifdef MULDIV_FAST_MUL_EN
                        acc_d   = prod_fast;
                        state_d = FIX;
`else
                        acc_d   = {{XLEN{1'b0}}, b_mag};
                        opb_d   = a_mag;
                        state_d = CALC;
`endif
                    end
                end
            end
            CALC: begin
                acc_d = op_q[2] ? acc_div : acc_mul;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST_IT) state_d = FIX;
            end
            FIX: begin
                result_d = fix_val;
                wa_d     = rd_q;
                state_d  = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers. Reset abandons any operation in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            wa_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            wa_q     <= wa_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign result = result_q;
    assign wa     = wa_q;
    assign we     = done_q && (wa_q != 5'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit. Each launch queues its expected result
// and latency. The entry is popped and compared when done pulses.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [4:0]  rd_in = '0;
    logic        busy, done, we;
    logic [31:0] result;
    logic [4:0]  wa;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .rd_in(rd_in), .busy(busy), .done(done), .result(result), .we(we), .wa(wa)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  wa;
        logic        we;
        int          lat;
        int          k;
    } exp_t;
    exp_t sb[$];

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] xs, ys, xz, yz, p;
        int sx, sy;
        logic ovf;
        xs = {{32{x[31]}}, x};
        ys = {{32{y[31]}}, y};
        xz = {32'd0, x};
        yz = {32'd0, y};
        sx = $signed(x);
        sy = $signed(y);
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        p = '0;
        case (o)
            3'd0: begin p = xz * yz; return p[31:0]; end
            3'd1: begin p = xs * ys; return p[63:32]; end
            3'd2: begin p = xs * yz; return p[63:32]; end
            3'd3: begin p = xz * yz; return p[63:32]; end
            3'd4: return (y == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sx / sy));
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: return (y == 0) ? x : (ovf ? 32'd0 : 32'(sx % sy));
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        if (!o[2]) return MUL_LAT;
        if (y == 0) return 2;
        if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 2;
        return 34;
    endfunction

    // Call at a negedge. Start is sampled at the following posedge.
    task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [4:0] rd, input logic [31:0] er);
        exp_t e;
        op = o; a = x; b = y; rd_in = rd; start = 1'b1;
        e.res = er; e.wa = rd; e.we = (rd != 0); e.lat = exp_lat(o, x, y); e.k = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom; rd_in = 5'($urandom); op = 3'($urandom);
    endtask

    task automatic wait_done(input string nm);
        exp_t e;
        bit seen;
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin seen = 1; break; end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s: done got none within 80 cycles, expected a pulse", nm);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        total++;
        if (result !== e.res) begin bad++; $display("FAIL %s result: got %h expected %h", nm, result, e.res); end
        total++;
        if (wa !== e.wa) begin bad++; $display("FAIL %s wa: got %0d expected %0d", nm, wa, e.wa); end
        total++;
        if (we !== e.we) begin bad++; $display("FAIL %s we: got %b expected %b", nm, we, e.we); end
        total++;
        if (cyc - e.k != e.lat) begin bad++; $display("FAIL %s latency: got %0d expected %0d", nm, cyc - e.k, e.lat); end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b expected 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset done: got %b expected 0", done); end
        total++; if (we !== 1'b0) begin bad++; $display("FAIL reset we: got %b expected 0", we); end
        total++; if (result !== 32'd0) begin bad++; $display("FAIL reset result: got %h expected 0", result); end
        total++; if (wa !== 5'd0) begin bad++; $display("FAIL reset wa: got %0d expected 0", wa); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul();
        launch(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB);
        wait_done("mul");
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL mul done_pulse: got %b expected 0", done); end
        launch(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE);
        wait_done("mulhu");
        launch(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd7, 32'hFFFF_FFFF);
        wait_done("mulhsu");
        launch(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd8, 32'h4000_0000);
        wait_done("mulh");
    endtask

    task automatic test_div();
        launch(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFD);
        wait_done("div");
        launch(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFF);
        wait_done("rem");
        launch(3'd5, 32'd1000, 32'd7, 5'd1, 32'd142);
        wait_done("divu");
        launch(3'd7, 32'd1000, 32'd7, 5'd2, 32'd6);
        wait_done("remu");
    endtask

    task automatic test_fast();
        launch(3'd5, 32'd100, 32'd0, 5'd4, 32'hFFFF_FFFF);
        wait_done("divu_zero");
        launch(3'd7, 32'd100, 32'd0, 5'd4, 32'd100);
        wait_done("remu_zero");
        launch(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000);
        wait_done("div_ovf");
        launch(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0);
        wait_done("rem_ovf");
    endtask

    task automatic test_rd0();
        launch(3'd0, 32'd3, 32'd4, 5'd0, 32'd12);
        wait_done("rd0");
    endtask

    task automatic test_back_to_back();
        launch(3'd5, 32'd81, 32'd9, 5'd14, 32'd9);
        wait_done("b2b_first");
        launch(3'd7, 32'd81, 32'd10, 5'd15, 32'd1);
        wait_done("b2b_second");
    endtask

    task automatic test_guard();
        exp_t e;
        int extra;
        // A start while busy must be ignored.
        launch(3'd5, 32'd1000, 32'd3, 5'd9, 32'd333);
        repeat (4) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL guard busy: got %b expected 1", busy); end
        op = 3'd0; a = 32'd5; b = 32'd5; rd_in = 5'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_ignored");
        extra = 0;
        for (int i = 0; i < 40; i++) begin @(negedge clk); if (done) extra++; end
        total++; if (extra != 0) begin bad++; $display("FAIL busy_ignored extra_done: got %0d expected 0", extra); end
        // A start in the DONE-state cycle must be ignored.
        launch(3'd5, 32'd50, 32'd5, 5'd2, 32'd10);
        repeat (33) @(negedge clk);
        op = 3'd0; a = 32'd2; b = 32'd2; rd_in = 5'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e = sb.pop_front();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL done_cycle_start done: got %b expected 1", done); end
        total++; if (result !== e.res) begin bad++; $display("FAIL done_cycle_start result: got %h expected %h", result, e.res); end
        total++; if (cyc - e.k != e.lat) begin bad++; $display("FAIL done_cycle_start latency: got %0d expected %0d", cyc - e.k, e.lat); end
        extra = 0;
        for (int i = 0; i < 40; i++) begin @(negedge clk); if (done) extra++; end
        total++; if (extra != 0) begin bad++; $display("FAIL done_cycle_start extra_done: got %0d expected 0", extra); end
    endtask

    task automatic test_abort();
        int extra;
        launch(3'd5, 32'd12345, 32'd7, 5'd8, 32'd1763);
        void'(sb.pop_back());
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort busy: got %b expected 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL abort done: got %b expected 0", done); end
        total++; if (we !== 1'b0) begin bad++; $display("FAIL abort we: got %b expected 0", we); end
        total++; if (result !== 32'd0) begin bad++; $display("FAIL abort result: got %h expected 0", result); end
        total++; if (wa !== 5'd0) begin bad++; $display("FAIL abort wa: got %0d expected 0", wa); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        extra = 0;
        for (int i = 0; i < 50; i++) begin @(negedge clk); if (done || we) extra++; end
        total++; if (extra != 0) begin bad++; $display("FAIL abort late_writeback: got %0d expected 0", extra); end
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] x, y;
        logic [4:0]  rd;
        for (int i = 0; i < 12; i++) begin
            o = 3'($urandom);
            x = $urandom;
            y = $urandom;
            if (i % 4 == 0) y = 32'd0;
            if (i % 5 == 1) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            if (i % 3 == 2) y = 32'($urandom_range(1, 300));
            rd = 5'($urandom_range(0, 31));
            launch(o, x, y, rd, model(o, x, y));
            wait_done("random");
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_fast();
        test_rd0();
        test_back_to_back();
        test_guard();
        test_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit. It sits directly upstream of the single-cycle register file's write port. It takes the two source operands read from the register file, computes the M-extension result over multiple cycles, and presents one write-back beat (`we`, `wa`, `result`) that drives `we3`, `ra3` and `wd3`. The pipeline control holds the core with `busy` until `done`.

## Interface
- `XLEN`, default 32: operand and result width; only 32 is supported.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low (0 = reset).
- `start`, input, 1: launch request; sampled only in IDLE.
- `op`, input, 3: funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `a`, input, 32: rs1 value (from `rd1`).
- `b`, input, 32: rs2 value (from `rd2`).
- `rd_in`, input, 5: destination register index.
- `busy`, output, 1: high whenever state is not IDLE.
- `done`, output, 1: one-cycle pulse; `result` is valid while it is high.
- `result`, output, 32: registered result; holds its value until the next `done`.
- `we`, output, 1: equals `done && (wa != 0)`.
- `wa`, output, 5: latched `rd_in`.

## Operation
- States are IDLE, CALC, FIX and DONE.
- **IDLE, with `start` = 1:**
  - Latch `op` and `rd_in`.
  - Latch the absolute values of the operands. An operand is treated as signed for MULH (both), MULHSU (`a` only), and DIV/REM (both).
  - Record the result sign: the sign of the quotient/product for signed ops, or the sign of the dividend for REM.
  - Clear the 6-bit iteration counter and go to CALC.
- **Fast path (IDLE → FIX, CALC skipped):**
  - Divide by zero (`b` = 0, any div op): quotient = 0xFFFFFFFF, remainder = `a` unmodified.
  - Signed overflow (DIV/REM with `a` = 0x80000000 and `b` = 0xFFFFFFFF): DIV = 0x80000000, REM = 0.
- **CALC:** one iteration per cycle, 32 iterations, then go to FIX.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring divide producing a 32-bit quotient and a 32-bit remainder.
- **FIX:**
  - Negate the magnitude result if the recorded sign requires it.
  - Select the output: low word (MUL), high word (MULH*), quotient or remainder.
  - Register the value into `result` and go to DONE.
- **DONE:** `done` = 1 for exactly one cycle, then go to IDLE.
- **Arithmetic rules:**
  - All negation is two's complement modulo 2^32 (64-bit for the product).
  - Remainder sign follows the dividend.
  - Quotient truncates toward zero.
- **Boundary conditions:**
  - `start` while `busy` is ignored; no queueing.
  - `start` in the cycle DONE returns to IDLE is ignored.
  - `rd_in` = 0: the computation runs and `done` pulses, but `we` stays 0.
  - Operands are latched at launch; changes on `a`/`b` after that have no effect.
- **Reset (at any time, including mid-CALC):**
  - Immediately forces IDLE.
  - `busy`, `done`, `we` = 0; `result` = 0; `wa` = 0; counter = 0.
  - No write-back is issued for the aborted operation.

## Timing
- `start` sampled at edge k.
- Iterative path:
  - CALC covers edges k+1 to k+32; FIX is at edge k+33.
  - `done` is high from edge k+34 until edge k+35.
  - Latency: 34 cycles from start edge to the `done` cycle.
- Fast path: FIX at edge k+1, `done` high between edges k+2 and k+3.
- `busy` rises after edge k and falls at the edge that leaves DONE.
- Back-to-back throughput: a new `start` can be sampled at the edge where the unit is back in IDLE, i.e. 35 edges after the previous start on the iterative path.
- `result`, `wa` and `we` change only at the edge entering DONE or on reset.

## Configuration
- `MULDIV_FAST_MUL_EN`
  - Defined: MUL/MULH/MULHSU/MULHU use a single-cycle 64-bit combinational multiply and take the fast path (`done` at k+2). Division is unchanged.
  - Undefined: every multiply op runs the 32-iteration CALC path.

## Test plan
- MUL, `a`=7, `b`=0xFFFFFFFD (−3), `rd_in`=5 → `result` 0xFFFFFFEB, `we`=1, `wa`=5.
  - Macro undefined: `done` exactly at k+34.
  - Macro defined: `done` at k+2.
- MULHU, `a`=`b`=0xFFFFFFFF → `result` 0xFFFFFFFE.
- MULHSU, `a`=0xFFFFFFFF, `b`=2 → `result` 0xFFFFFFFF.
- DIV, `a`=0xFFFFFFF9 (−7), `b`=2 → 0xFFFFFFFD.
- REM, same operands → 0xFFFFFFFF.
- DIVU, `a`=100, `b`=0 → 0xFFFFFFFF with `done` at k+2.
- REMU, same operands → 100.
- DIV, `a`=0x80000000, `b`=0xFFFFFFFF → 0x80000000; REM with the same operands → 0. Both have `done` at k+2.
- Reset and guard cases:
  - Start DIVU, drive `reset`=0 at k+10 → `busy`=0 immediately, no `done`/`we` afterwards.
  - A second `start` during `busy` is ignored.
  - `rd_in`=0 → `done`=1 with `we`=0.
